// File: rtl/serial_pkg.sv
// Shared definitions for the display serial link: frame length, synchronizer depth,
// receiver state encoding and pin indices for the conditioned input bus.
package serial_pkg;

    localparam int WIDTH_DEFAULT       = 32;
    localparam int SYNC_STAGES_DEFAULT = 2;

    // Bit positions of the link pins on the receiver's conditioned input vector
    localparam int PIN_SCLK = 0;
    localparam int PIN_DE   = 1;
    localparam int PIN_SDO  = 2;
    localparam int PIN_DCLK = 3;
    localparam int NUM_PINS = 4;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        FULL  = 2'd2,
        DROP  = 2'd3
    } rx_state_t;

    // One spare bit so the counter can hold the value WIDTH itself
    function automatic int cnt_width(input int w);
        return $clog2(w) + 1;
    endfunction

endpackage

// File: rtl/serial_rx_sync_edge.sv
// Multi-flop synchronizer for one asynchronous pin, with rise/fall event pulses
// derived from the last stage and one extra delay flop.
module sync_edge #(
    parameter int STAGES = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic din,
    output logic level,
    output logic rise,
    output logic fall
);

    logic [STAGES-1:0] sync_reg;
    logic              delay_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_reg  <= '0;
            delay_reg <= 1'b0;
        end else begin
            sync_reg  <= {sync_reg[STAGES-2:0], din};
            delay_reg <= sync_reg[STAGES-1];
        end
    end

    assign level = sync_reg[STAGES-1];
    assign rise  = sync_reg[STAGES-1] & ~delay_reg;
    assign fall  = ~sync_reg[STAGES-1] & delay_reg;

endmodule

// File: rtl/serial_rx.sv
// Display serial link receiver: oversamples sclk/data_enable/sdo/dclk, rebuilds
// MSB-first frames, flags short/overlong frames and commits good frames on dclk.
module serial_rx
    import serial_pkg::*;
#(
    parameter int WIDTH       = WIDTH_DEFAULT,
    parameter int SYNC_STAGES = SYNC_STAGES_DEFAULT
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             sclk,
    input  logic             data_enable,
    input  logic             sdo,
    input  logic             dclk,
    output logic [WIDTH-1:0] data_out,
    output logic             data_valid,
    output logic [WIDTH-1:0] display_word,
    output logic             frame_err,
    output logic             busy
);

    localparam int              CNT_W    = cnt_width(WIDTH);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(WIDTH);

    logic [NUM_PINS-1:0] pin_vec;
    logic [NUM_PINS-1:0] level_vec;
    logic [NUM_PINS-1:0] rise_vec;
    logic [NUM_PINS-1:0] fall_vec;

    assign pin_vec[PIN_SCLK] = sclk;
    assign pin_vec[PIN_DE]   = data_enable;
    assign pin_vec[PIN_SDO]  = sdo;
    assign pin_vec[PIN_DCLK] = dclk;

    genvar gi;
    generate
        for (gi = 0; gi < NUM_PINS; gi++) begin : g_pin_sync
            sync_edge #(
                .STAGES(SYNC_STAGES)
            ) u_sync_edge (
                .clk  (clk),
                .rst_n(rst_n),
                .din  (pin_vec[gi]),
                .level(level_vec[gi]),
                .rise (rise_vec[gi]),
                .fall (fall_vec[gi])
            );
        end
    endgenerate

    logic sclk_rise;
    logic de_rise;
    logic de_fall;
    logic sdo_level;
    logic dclk_rise;

    assign sclk_rise = rise_vec[PIN_SCLK];
    assign de_rise   = rise_vec[PIN_DE];
    assign de_fall   = fall_vec[PIN_DE];
    assign sdo_level = level_vec[PIN_SDO];
    assign dclk_rise = rise_vec[PIN_DCLK];

    // Event/level bits the frame logic has no use for
    logic unused_pin_bits;
    assign unused_pin_bits = ^{level_vec[PIN_SCLK], level_vec[PIN_DE], level_vec[PIN_DCLK],
                               fall_vec[PIN_SCLK], fall_vec[PIN_DCLK],
                               rise_vec[PIN_SDO], fall_vec[PIN_SDO]};

    rx_state_t        state_reg,        state_next;
    logic [CNT_W-1:0] bit_cnt_reg,      bit_cnt_next;
    logic [WIDTH-1:0] shift_reg,        shift_next;
    logic [WIDTH-1:0] data_out_reg,     data_out_next;
    logic [WIDTH-1:0] display_reg,      display_next;
    logic             data_valid_reg,   data_valid_next;
    logic             frame_err_reg,    frame_err_next;

    logic [WIDTH-1:0] shift_in;
    logic [CNT_W-1:0] cnt_inc;

    assign shift_in = {shift_reg[WIDTH-2:0], sdo_level};
    assign cnt_inc  = (bit_cnt_reg == CNT_FULL) ? bit_cnt_reg : bit_cnt_reg + CNT_W'(1);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg      <= IDLE;
            bit_cnt_reg    <= '0;
            shift_reg      <= '0;
            data_out_reg   <= '0;
            display_reg    <= '0;
            data_valid_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
        end else begin
            state_reg      <= state_next;
            bit_cnt_reg    <= bit_cnt_next;
            shift_reg      <= shift_next;
            data_out_reg   <= data_out_next;
            display_reg    <= display_next;
            data_valid_reg <= data_valid_next;
            frame_err_reg  <= frame_err_next;
        end
    end

    always_comb begin
        state_next      = state_reg;
        bit_cnt_next    = bit_cnt_reg;
        shift_next      = shift_reg;
        data_out_next   = data_out_reg;
        data_valid_next = 1'b0;
        frame_err_next  = 1'b0;
        display_next    = display_reg;

        case (state_reg)
            IDLE: begin
                if (de_rise) begin
                    shift_next   = '0;
                    bit_cnt_next = '0;
                    state_next   = SHIFT;
                end
            end
            SHIFT: begin
                // A bit arriving with the closing strobe is shifted before the count is judged
                if (sclk_rise) begin
                    shift_next   = shift_in;
                    bit_cnt_next = cnt_inc;
                end
                if (de_fall) begin
                    state_next = IDLE;
                    if (bit_cnt_next == CNT_FULL) begin
                        data_out_next   = shift_next;
                        data_valid_next = 1'b1;
                    end else begin
                        frame_err_next = 1'b1;
                    end
                end else if (bit_cnt_next == CNT_FULL) begin
                    state_next = FULL;
                end
            end
            FULL: begin
                if (sclk_rise) begin
                    frame_err_next = 1'b1;
                    state_next     = de_fall ? IDLE : DROP;
                end else if (de_fall) begin
                    data_out_next   = shift_reg;
                    data_valid_next = 1'b1;
                    state_next      = IDLE;
                end
            end
            DROP: begin
                if (de_fall) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase

        // data_out_next already carries a frame completing this cycle (write-through)
        if (dclk_rise) begin
            display_next = data_out_next;
        end
    end

    assign data_out     = data_out_reg;
    assign data_valid   = data_valid_reg;
    assign display_word = display_reg;
    assign frame_err    = frame_err_reg;
    assign busy         = (state_reg != IDLE);

endmodule

// File: tb/tb_serial_rx.sv
// Directed bench for serial_rx: reset, good/short/overlong frames, dclk commit,
// reset mid-frame and a slow transmitter-rate frame.
module tb_serial_rx;

    localparam int WIDTH = 32;
    localparam int SYNC  = 2;
    localparam int HALF  = 6;

    logic             clk         = 1'b0;
    logic             rst_n       = 1'b0;
    logic             sclk        = 1'b0;
    logic             data_enable = 1'b0;
    logic             sdo         = 1'b0;
    logic             dclk        = 1'b0;
    logic [WIDTH-1:0] data_out;
    logic             data_valid;
    logic [WIDTH-1:0] display_word;
    logic             frame_err;
    logic             busy;

    int pass_cnt  = 0;
    int check_cnt = 0;
    int dv_cnt    = 0;
    int fe_cnt    = 0;
    int both_cnt  = 0;
    int wide_cnt  = 0;
    logic dv_prev = 1'b0;
    logic fe_prev = 1'b0;

    serial_rx #(
        .WIDTH      (WIDTH),
        .SYNC_STAGES(SYNC)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .sclk        (sclk),
        .data_enable (data_enable),
        .sdo         (sdo),
        .dclk        (dclk),
        .data_out    (data_out),
        .data_valid  (data_valid),
        .display_word(display_word),
        .frame_err   (frame_err),
        .busy        (busy)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end

    // Pulse bookkeeping, sampled mid-cycle
    always @(negedge clk) begin
        if (!rst_n) begin
            dv_prev = 1'b0;
            fe_prev = 1'b0;
        end else begin
            if (data_valid) dv_cnt++;
            if (frame_err) fe_cnt++;
            if (data_valid && frame_err) both_cnt++;
            if ((data_valid && dv_prev) || (frame_err && fe_prev)) wide_cnt++;
            dv_prev = data_valid;
            fe_prev = frame_err;
        end
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        check_cnt++;
        assert (obs === exp) pass_cnt++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic open_frame();
        data_enable = 1'b1;
        cycles(6);
    endtask

    task automatic send_bits(input logic [31:0] word, input int nbits, input int half);
        for (int i = 0; i < nbits; i++) begin
            sdo = (i < 32) ? word[31-i] : 1'b0;
            cycles(half);
            sclk = 1'b1;
            cycles(half);
            sclk = 1'b0;
        end
    endtask

    task automatic close_frame(input int half);
        cycles(half);
        data_enable = 1'b0;
        cycles(10);
    endtask

    task automatic send_frame(input logic [31:0] word);
        open_frame();
        send_bits(word, 32, HALF);
        close_frame(HALF);
    endtask

    task automatic pulse_dclk();
        dclk = 1'b1;
        cycles(6);
        dclk = 1'b0;
        cycles(6);
    endtask

    initial begin
        int lat;
        int dv0;
        int fe0;

        // Reset held with random pin activity
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            sclk        = 1'($urandom_range(0, 1));
            data_enable = 1'($urandom_range(0, 1));
            sdo         = 1'($urandom_range(0, 1));
            dclk        = 1'($urandom_range(0, 1));
        end
        check("rst_data_out", data_out, 32'h0);
        check("rst_display", display_word, 32'h0);
        check("rst_data_valid", 32'(data_valid), 32'h0);
        check("rst_frame_err", 32'(frame_err), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        sclk = 1'b0; data_enable = 1'b0; sdo = 1'b0; dclk = 1'b0;
        cycles(5);
        rst_n = 1'b1;
        cycles(5);

        // dclk before any good frame keeps zero
        pulse_dclk();
        check("display_no_frame", display_word, 32'h0);

        // First frame with latency measurement from data_enable fall
        open_frame();
        send_bits(32'h00001234, 32, HALF);
        cycles(HALF);
        data_enable = 1'b0;
        lat = 0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (data_valid) begin
                lat = i;
                break;
            end
        end
        check("dv_latency", 32'(lat), 32'(SYNC + 1));
        check("frame_1234", data_out, 32'h00001234);
        cycles(10);

        // Display commit, then a frame with no dclk
        send_frame(32'hDEADBEEF);
        pulse_dclk();
        check("display_deadbeef", display_word, 32'hDEADBEEF);
        send_frame(32'h01020304);
        check("display_held", display_word, 32'hDEADBEEF);
        check("frame_01020304", data_out, 32'h01020304);

        // Short frame: 31 bits
        dv0 = dv_cnt; fe0 = fe_cnt;
        open_frame();
        send_bits(32'hFFFFFFFF, 31, HALF);
        close_frame(HALF);
        check("short_frame_err", 32'(fe_cnt - fe0), 32'd1);
        check("short_no_valid", 32'(dv_cnt - dv0), 32'd0);
        check("short_data_kept", data_out, 32'h01020304);

        // Overlong frame: error on the 33rd edge, nothing at frame end
        dv0 = dv_cnt; fe0 = fe_cnt;
        open_frame();
        send_bits(32'h12345678, 32, HALF);
        check("long_no_err_at_32", 32'(fe_cnt - fe0), 32'd0);
        send_bits(32'h00000000, 1, HALF);
        check("long_err_at_33", 32'(fe_cnt - fe0), 32'd1);
        close_frame(HALF);
        check("long_no_valid", 32'(dv_cnt - dv0), 32'd0);
        check("long_one_err", 32'(fe_cnt - fe0), 32'd1);
        check("long_data_kept", data_out, 32'h01020304);
        send_frame(32'hA5A5A5A5);
        check("frame_a5a5a5a5", data_out, 32'hA5A5A5A5);

        // Reset in the middle of a frame
        open_frame();
        send_bits(32'hCAFEF00D, 16, HALF);
        check("midframe_busy", 32'(busy), 32'h1);
        rst_n = 1'b0;
        data_enable = 1'b0;
        sclk = 1'b0;
        @(negedge clk);
        check("midrst_busy", 32'(busy), 32'h0);
        check("midrst_data_out", data_out, 32'h0);
        check("midrst_display", display_word, 32'h0);
        check("midrst_valid", 32'(data_valid), 32'h0);
        cycles(5);
        rst_n = 1'b1;
        cycles(5);
        check("post_rst_idle", 32'(busy), 32'h0);
        send_frame(32'h00000001);
        check("frame_after_rst", data_out, 32'h00000001);

        // Transmitter-rate frame: digits 1234 as BCD nibbles, sclk half-period 257
        open_frame();
        send_bits(32'h00001234, 32, 257);
        close_frame(257);
        check("loopback_data", data_out, 32'h00001234);
        pulse_dclk();
        check("loopback_display", display_word, 32'h00001234);

        // Pulse shape over the whole run
        check("pulse_exclusive", 32'(both_cnt), 32'd0);
        check("pulse_one_cycle", 32'(wide_cnt), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, check_cnt);
        $finish;
    end

endmodule
